// File: rtl/cmp_iter_mag.sv
// cmp_iter_mag - multi-cycle magnitude comparator for the ALU compare path.
//
// Scans the operands CHUNK bits per cycle from the most significant chunk
// down to chunk 0 and reports one-hot gt/eq/lt flags. Signed compares are
// turned into unsigned ones by flipping the sign bit of both operands at
// capture time.
//
// Optional build macro: CMP_ITER_EARLY_EXIT_EN
//   When defined, the scan ends at the first differing chunk. Only the latency
//   changes; the flag values are the same in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode valid
//   in_ready   block can accept new operands (IDLE only)
//   a, b       operands, WIDTH bits
//   is_signed  1 = two's-complement compare, 0 = unsigned
//   out_valid  result flags valid (DONE only)
//   out_ready  consumer accepts result
//   gt/eq/lt   one-hot compare result, held until the next result
//
// States:
//   IDLE | waiting for operands, in_ready=1
//   SCAN | comparing chunk idx, one chunk per cycle
//   DONE | result presented, waiting for out_ready
module cmp_iter_mag #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("cmp_iter_mag: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             res_gt_q, res_gt_d;   // direction of the first differing chunk
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] a_ch [NCHUNK];
  logic [CHUNK-1:0] b_ch [NCHUNK];
  logic [CHUNK-1:0] a_cur, b_cur;
  logic             chunk_ne, chunk_gt, finish;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
    assign a_ch[i] = a_q[i*CHUNK +: CHUNK];
    assign b_ch[i] = b_q[i*CHUNK +: CHUNK];
  end

  assign a_cur    = a_ch[idx_q];
  assign b_cur    = b_ch[idx_q];
  assign chunk_ne = (a_cur != b_cur);
  assign chunk_gt = (a_cur > b_cur);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    res_gt_d  = res_gt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          // Sign-bias: flipping the MSB maps two's complement onto unsigned order.
          if (is_signed) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          idx_d     = IDX_LAST;
          decided_d = 1'b0;
          res_gt_d  = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (!decided_q && chunk_ne) begin
          decided_d = 1'b1;
          res_gt_d  = chunk_gt;
        end
        if (idx_q == '0) begin
          finish = 1'b1;
        end
`ifdef CMP_ITER_EARLY_EXIT_EN
        else if (!decided_q && chunk_ne) begin
          finish = 1'b1;
        end
`endif
        else begin
          idx_d = idx_q - IDX_W'(1);
        end
        // The visible flags only change on entry to DONE, so they never show a
        // partial result while out_valid is low.
        if (finish) begin
          gt_d    = decided_d & res_gt_d;
          lt_d    = decided_d & ~res_gt_d;
          eq_d    = ~decided_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_gt_q  <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      res_gt_q  <= res_gt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;

endmodule

// File: doc/cmp_iter_mag.md
Name: cmp_iter_mag

Overview:
Parametrised multi-cycle magnitude comparator for the ALU compare path. It is the successor to the fixed 32-bit greater-than block.
- Width is generic; unsigned and signed (two's complement) modes are supported.
- Produces one-hot GT/EQ/LT flags instead of a single GT bit.
- Scans CHUNK bits per cycle from MSB to LSB, trading latency for area.
- Valid/ready handshakes on both input and output, so it sits between the operand register stage and the ALU result mux.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8, bits compared per cycle; CHUNK == WIDTH gives a single scan cycle.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept new operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned
- out_valid  out  1  result flags valid
- out_ready  in  1  consumer accepts result
- gt  out  1  A > B
- eq  out  1  A == B
- lt  out  1  A < B

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, gt=eq=lt=0, internal operand/index registers cleared. Takes effect immediately, including mid-scan; any in-flight operation is discarded with no result.
- NCHUNK = WIDTH/CHUNK. Chunk index 0 = LSB chunk.
- State IDLE (in_ready=1):
  - On in_valid&&in_ready at a rising edge, capture a and b.
  - If is_signed=1, invert bit WIDTH-1 of both captured copies (sign-bias) so the rest of the compare is unsigned.
  - Set idx=NCHUNK-1, clear decided flag, go to SCAN. in_ready drops the same edge.
- State SCAN (in_ready=0, out_valid=0): each cycle, compare chunk idx of A against chunk idx of B (unsigned).
  - If not yet decided and chunks differ: latch gt or lt and set decided.
  - Once decided, the result is sticky and later chunks are ignored.
  - If idx==0: at the same edge latch eq = !decided, then go to DONE. Otherwise idx decrements.
- State DONE:
  - out_valid=1 and exactly one of gt/eq/lt is 1.
  - Flags and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 and in_ready=1 from the next cycle. Flags may hold their last value in IDLE.
  - No new operand is accepted in DONE (in_ready=0); there is no accept-and-return in the same cycle.
- Latency (baseline): out_valid rises exactly NCHUNK clock edges after the accept edge, independent of data.
- Throughput: at most one result per NCHUNK+2 cycles.
- in_valid while in_ready=0 is ignored. Operands need not be held after acceptance.
- Flags are never asserted simultaneously, and are never asserted while out_valid=0 after reset until the first DONE.

Optional Feature:
- Macro: CMP_ITER_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE at the edge where the first differing chunk is found, with latency = number of chunks examined (1..NCHUNK). eq=1 results still take NCHUNK cycles.
- Undefined: fixed NCHUNK-cycle latency as in Behaviour.
- Flag values are identical in both builds.

Test Plan (WIDTH=32, CHUNK=8):
1. Unsigned a=0x00000001, b=0x00000000 -> gt=1, eq=0, lt=0; out_valid 4 edges after accept in both builds, since the difference is in chunk 0.
2. a=b=0xDEADBEEF, unsigned and signed -> eq=1 in both; latency 4 in both builds.
3. a=0xFFFFFFFF, b=0x00000001 -> unsigned gives gt=1; signed gives lt=1 (-1 < 1). Also a=0x80000000, b=0x7FFFFFFF signed -> lt=1.
4. Unsigned a=0x80000000, b=0x7FFFFFFF -> gt=1; latency 4 without CMP_ITER_EARLY_EXIT_EN, latency 1 with it.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with new operands during SCAN/DONE -> out_valid and flags stay stable, in_ready stays 0, and the new operands are not taken. Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle; the next transaction returns the correct result.
6. Assert rst_n=0 asynchronously (off clock edge) during SCAN idx=2 -> in_ready=1, out_valid=0, flags=0 immediately. After release, a=5, b=9 unsigned -> lt=1 with normal latency.
